h14_packet_disassembler: RTL and testbench
==========================================

Name: h14_packet_disassembler

Overview:
Receive-side counterpart of the TMDS data-island packet assembler. It takes the 9-bit per-cycle chunk stream of one 32-cycle data-island packet and deserializes it back into a 24-bit header and four 56-bit subpackets. It recomputes the BCH ECC for all five blocks and compares it with the received parity bytes. It sits after TERC4 decode in loopback/verification paths and in any HDMI sink datapath built on this core.

Parameters:
None. Packet geometry is fixed by HDMI 1.4 Section 5.2.3.4: 32 cycles, 24+8 header bits, 4 x (56+8) subpacket bits.

Ports:
clk  in  1  pixel/TMDS character clock
rst_n  in  1  asynchronous active-low reset
active  in  1  high while a data-island packet period is in progress; a chunk is sampled on every cycle with active=1
chunk  in  9  {bch3[2c+1], bch2[2c+1], bch1[2c+1], bch0[2c+1], bch3[2c], bch2[2c], bch1[2c], bch0[2c], bch4[c]}, where c = counter
header  out  24  header of the last completed packet
sub  out  56 x [3:0]  subpackets of the last completed packet
ecc_err  out  5  bit i=1: parity mismatch on subpacket i (i=0..3); bit 4: header
pkt_valid  out  1  one-cycle pulse when header/sub/ecc_err update
counter  out  5  current chunk index 0..31

Behaviour:
- Reset:
  - counter=0, pkt_valid=0, header=0, sub=all 0, ecc_err=0.
  - Internal shift/assembly registers and the five running ECC registers are cleared.
- counter: increments by 1 on each active cycle, wrapping 31->0. When active=0, counter is forced to 0 on the next edge (abort).
- Data capture, counter c, active=1:
  - Header bit c <- chunk[0] for c<24; header parity bit (c-24) <- chunk[0] for c>=24.
  - Subpacket i bit 2c <- chunk[1+i] and bit 2c+1 <- chunk[5+i] for c<28.
  - For c>=28 the same chunk bits land in subpacket i parity bits 2(c-28) and 2(c-28)+1.
- ECC step function, identical to TX: e' = (e>>1) ^ ((e[0]^bit) ? 8'h83 : 8'h00).
  - Header: one step per cycle, c<24.
  - Subpackets: two steps per cycle (bit 2c, then bit 2c+1), c<28.
  - Parity bits never feed the ECC.
- Completion, on the edge that samples c=31 with active=1:
  - header, sub, and ecc_err[i] (computed != received parity) are registered.
  - pkt_valid=1 for exactly that following cycle.
  - Running ECC and assembly registers are cleared for the next packet.
- Latency: outputs valid 1 cycle after the 32nd chunk. Back-to-back packets (active held high for 64+ cycles) produce a pkt_valid every 32 cycles with no gap.
- Abort: if active drops at any c (including c=31, where the chunk is not sampled):
  - No pkt_valid is produced and outputs keep the previous packet.
  - ECC and assembly registers clear.
  - The next active cycle is treated as c=0.
- Reset asserted mid-packet: all state returns to reset values immediately; the partial packet is discarded.
- Outputs hold between packets. ecc_err is meaningful only alongside the matching pkt_valid/header/sub.

Optional Feature:
Macro H14_PKT_ERR_COUNT_EN.
- Defined: adds output err_count [15:0], reset 0.
  - Increments by 1 on each pkt_valid cycle where |ecc_err=1.
  - Saturates at 16'hFFFF.
  - Is cleared only by rst_n.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- All-zero packet, active high 32 cycles -> pkt_valid pulse at cycle 32 (one cycle after the 32nd sample); header=0, sub=0, ecc_err=5'b00000; counter back to 0.
- Header 24'h000001, header parity 8'h4A, subpackets 0 with parity 0 -> ecc_err=0. Same stimulus with header parity 8'h4B -> ecc_err=5'b10000.
- Stream produced by the TX assembler with random header and subs, then one flipped bit in sub[2] data at c=10 -> ecc_err=5'b00100; header and sub[2] show the flipped value.
- Three back-to-back packets, active held 96 cycles -> pkt_valid at cycles 32, 64 and 96, each with the correct decoded payload.
- active dropped at c=17, then a full valid packet -> no pulse for the aborted packet; the second packet decodes with ecc_err=0. Also assert rst_n low at c=5 -> all outputs return to 0.
- With H14_PKT_ERR_COUNT_EN: 3 corrupted packets -> err_count=3. Preload near saturation via 65537 error packets (or force) -> err_count holds at 16'hFFFF.

Source files
------------

// File: rtl/h14_packet_disassembler_if.sv
// Chunk-stream input and decoded-packet output bundle for h14_packet_disassembler.
// err_count exists only when H14_PKT_ERR_COUNT_EN is defined.
interface h14_packet_disassembler_if;
    logic             active;
    logic [8:0]       chunk;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [4:0]       ecc_err;
    logic             pkt_valid;
    logic [4:0]       counter;
`ifdef H14_PKT_ERR_COUNT_EN
    logic [15:0]      err_count;

    modport master (
        output active, chunk,
        input  header, sub, ecc_err, pkt_valid, counter, err_count
    );
    modport slave (
        input  active, chunk,
        output header, sub, ecc_err, pkt_valid, counter, err_count
    );
`else
    modport master (
        output active, chunk,
        input  header, sub, ecc_err, pkt_valid, counter
    );
    modport slave (
        input  active, chunk,
        output header, sub, ecc_err, pkt_valid, counter
    );
`endif
endinterface

// File: rtl/h14_packet_disassembler.sv
// Deserializes one 32-cycle TMDS data-island packet into header + 4 subpackets and checks BCH parity.
// Optional saturating packet-error counter enabled by macro H14_PKT_ERR_COUNT_EN.
module h14_packet_disassembler (
    input  logic                       clk,
    input  logic                       rst_n,
    h14_packet_disassembler_if.slave   bus
);

    localparam logic [7:0] ECC_POLY = 8'h83;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        ecc_step = (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? ECC_POLY : 8'h00);
    endfunction

    logic [4:0]       cnt_q, cnt_d;
    logic [23:0]      hdr_asm_q, hdr_asm_d;
    logic [7:0]       hpar_q, hpar_d;
    logic [7:0]       hecc_q, hecc_d;
    logic [3:0][55:0] sub_asm_q, sub_asm_d;
    logic [3:0][7:0]  spar_q, spar_d;
    logic [3:0][7:0]  secc_q, secc_d;

    logic [23:0]      header_q, header_d;
    logic [3:0][55:0] sub_q, sub_d;
    logic [4:0]       ecc_err_q, ecc_err_d;
    logic             pkt_valid_q, pkt_valid_d;

    logic [5:0]       sidx_lo, sidx_hi;
    logic [2:0]       pidx_lo, pidx_hi;

    always_comb begin
        cnt_d       = cnt_q;
        hdr_asm_d   = hdr_asm_q;
        hpar_d      = hpar_q;
        hecc_d      = hecc_q;
        sub_asm_d   = sub_asm_q;
        spar_d      = spar_q;
        secc_d      = secc_q;
        header_d    = header_q;
        sub_d       = sub_q;
        ecc_err_d   = ecc_err_q;
        pkt_valid_d = 1'b0;
        sidx_lo     = {cnt_q, 1'b0};
        sidx_hi     = {cnt_q, 1'b1};
        pidx_lo     = {cnt_q[1:0], 1'b0};
        pidx_hi     = {cnt_q[1:0], 1'b1};

        if (!bus.active) begin
            // Abort: drop any partial packet, published outputs are untouched.
            cnt_d     = 5'd0;
            hdr_asm_d = '0;
            hpar_d    = '0;
            hecc_d    = '0;
            sub_asm_d = '0;
            spar_d    = '0;
            secc_d    = '0;
        end else begin
            cnt_d = cnt_q + 5'd1;

            if (cnt_q < 5'd24) begin
                hdr_asm_d[cnt_q] = bus.chunk[0];
                hecc_d           = ecc_step(hecc_q, bus.chunk[0]);
            end else begin
                hpar_d[cnt_q[2:0]] = bus.chunk[0];
            end

            for (int i = 0; i < 4; i++) begin
                if (cnt_q < 5'd28) begin
                    sub_asm_d[i][sidx_lo] = bus.chunk[1+i];
                    sub_asm_d[i][sidx_hi] = bus.chunk[5+i];
                    secc_d[i] = ecc_step(ecc_step(secc_q[i], bus.chunk[1+i]), bus.chunk[5+i]);
                end else begin
                    spar_d[i][pidx_lo] = bus.chunk[1+i];
                    spar_d[i][pidx_hi] = bus.chunk[5+i];
                end
            end

            if (cnt_q == 5'd31) begin
                // Last parity bits arrive this cycle, so compare against the merged values.
                header_d     = hdr_asm_d;
                sub_d        = sub_asm_d;
                ecc_err_d[4] = (hecc_d != hpar_d);
                for (int i = 0; i < 4; i++) begin
                    ecc_err_d[i] = (secc_d[i] != spar_d[i]);
                end
                pkt_valid_d = 1'b1;
                hdr_asm_d   = '0;
                hpar_d      = '0;
                hecc_d      = '0;
                sub_asm_d   = '0;
                spar_d      = '0;
                secc_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hdr_asm_q   <= '0;
            hpar_q      <= '0;
            hecc_q      <= '0;
            sub_asm_q   <= '0;
            spar_q      <= '0;
            secc_q      <= '0;
            header_q    <= '0;
            sub_q       <= '0;
            ecc_err_q   <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hdr_asm_q   <= hdr_asm_d;
            hpar_q      <= hpar_d;
            hecc_q      <= hecc_d;
            sub_asm_q   <= sub_asm_d;
            spar_q      <= spar_d;
            secc_q      <= secc_d;
            header_q    <= header_d;
            sub_q       <= sub_d;
            ecc_err_q   <= ecc_err_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    assign bus.header    = header_q;
    assign bus.sub       = sub_q;
    assign bus.ecc_err   = ecc_err_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.counter   = cnt_q;

`ifdef H14_PKT_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (pkt_valid_q && (|ecc_err_q) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_h14_packet_disassembler.sv
// Scoreboard bench for h14_packet_disassembler: packets are serialized here, expected payloads queued
// at send time and compared when pkt_valid is seen.
module tb_h14_packet_disassembler;

    typedef logic [3:0][55:0] sub_t;
    typedef logic [3:0][7:0]  spar_t;
    typedef struct {
        logic [23:0] hdr;
        sub_t        sub;
        logic [4:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    h14_packet_disassembler_if bus();

    h14_packet_disassembler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ecc_calc(input logic [63:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < n; k++) begin
            e = (e >> 1) ^ (((e[0] ^ d[k]) == 1'b1) ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    task automatic make_parity(input logic [23:0] hdr, input sub_t sub,
                               output logic [7:0] hpar, output spar_t spar);
        hpar = ecc_calc({40'h0, hdr}, 24);
        for (int i = 0; i < 4; i++) spar[i] = ecc_calc({8'h0, sub[i]}, 56);
    endtask

    task automatic push_exp(input logic [23:0] hdr, input sub_t sub, input logic [4:0] err);
        exp_t e;
        e.hdr = hdr;
        e.sub = sub;
        e.err = err;
        sbq.push_back(e);
    endtask

    task automatic send_pkt(input logic [23:0] hdr, input logic [7:0] hpar, input sub_t sub,
                            input spar_t spar, input int ncyc);
        logic [31:0] hd;
        logic [63:0] sd [4];
        logic [8:0]  ch;
        hd = {hpar, hdr};
        for (int i = 0; i < 4; i++) sd[i] = {spar[i], sub[i]};
        for (int c = 0; c < ncyc; c++) begin
            ch[0] = hd[c];
            for (int i = 0; i < 4; i++) begin
                ch[1+i] = sd[i][2*c];
                ch[5+i] = sd[i][2*c+1];
            end
            @(negedge clk);
            bus.active = 1'b1;
            bus.chunk  = ch;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.active = 1'b0;
            bus.chunk  = '0;
        end
    endtask

    function automatic sub_t rand_sub();
        sub_t s;
        for (int i = 0; i < 4; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.pkt_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pkt_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("header", {40'h0, bus.header}, {40'h0, e.hdr});
                for (int i = 0; i < 4; i++) chk($sformatf("sub%0d", i), {8'h0, bus.sub[i]}, {8'h0, e.sub[i]});
                chk("ecc_err", {59'h0, bus.ecc_err}, {59'h0, e.err});
                if (e.err != 5'd0) exp_errs++;
            end
        end
    end

    initial begin
        logic [23:0] hdr;
        logic [7:0]  hpar;
        sub_t        sub;
        spar_t       spar;

        bus.active = 1'b0;
        bus.chunk  = '0;
        repeat (3) @(negedge clk);
        chk("rst_header", {40'h0, bus.header}, 64'd0);
        for (int i = 0; i < 4; i++) chk("rst_sub", {8'h0, bus.sub[i]}, 64'd0);
        chk("rst_ecc_err", {59'h0, bus.ecc_err}, 64'd0);
        chk("rst_pkt_valid", {63'h0, bus.pkt_valid}, 64'd0);
        chk("rst_counter", {59'h0, bus.counter}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // All-zero packet: pulse one cycle after the 32nd sample, counter wrapped to 0.
        push_exp(24'h0, '0, 5'b00000);
        send_pkt(24'h0, 8'h00, '0, '0, 32);
        @(negedge clk);
        chk("pv_after_32", {63'h0, bus.pkt_valid}, 64'd1);
        chk("counter_wrap", {59'h0, bus.counter}, 64'd0);
        bus.active = 1'b0;
        @(negedge clk);
        chk("pv_one_cycle", {63'h0, bus.pkt_valid}, 64'd0);
        idle(2);

        // Known header parity vector, good and corrupted.
        push_exp(24'h000001, '0, 5'b00000);
        send_pkt(24'h000001, 8'h4A, '0, '0, 32);
        idle(2);
        push_exp(24'h000001, '0, 5'b10000);
        send_pkt(24'h000001, 8'h4B, '0, '0, 32);
        idle(2);

        // Random packet with one data bit of sub[2] flipped at c=10 after parity was generated.
        hdr = $urandom();
        sub = rand_sub();
        make_parity(hdr, sub, hpar, spar);
        sub[2][20] = ~sub[2][20];
        push_exp(hdr, sub, 5'b00100);
        send_pkt(hdr, hpar, sub, spar, 32);
        idle(2);

        // Three back-to-back packets, active never drops.
        for (int p = 0; p < 3; p++) begin
            hdr = $urandom();
            sub = rand_sub();
            make_parity(hdr, sub, hpar, spar);
            push_exp(hdr, sub, 5'b00000);
            send_pkt(hdr, hpar, sub, spar, 32);
        end
        idle(3);

        // Abort at c=17, then a full good packet.
        hdr = $urandom();
        sub = rand_sub();
        make_parity(hdr, sub, hpar, spar);
        send_pkt(hdr, hpar, sub, spar, 17);
        @(negedge clk);
        chk("counter_mid", {59'h0, bus.counter}, 64'd17);
        bus.active = 1'b0;
        bus.chunk  = '0;
        @(negedge clk);
        chk("counter_abort", {59'h0, bus.counter}, 64'd0);
        hdr = $urandom();
        sub = rand_sub();
        make_parity(hdr, sub, hpar, spar);
        push_exp(hdr, sub, 5'b00000);
        send_pkt(hdr, hpar, sub, spar, 32);
        idle(3);

        // Reset mid-packet at c=5 clears everything immediately.
        hdr = $urandom();
        sub = rand_sub();
        make_parity(hdr, sub, hpar, spar);
        send_pkt(hdr, hpar, sub, spar, 5);
        @(negedge clk);
        rst_n = 1'b0;
        bus.active = 1'b0;
        #1;
        chk("mrst_header", {40'h0, bus.header}, 64'd0);
        for (int i = 0; i < 4; i++) chk("mrst_sub", {8'h0, bus.sub[i]}, 64'd0);
        chk("mrst_ecc_err", {59'h0, bus.ecc_err}, 64'd0);
        chk("mrst_counter", {59'h0, bus.counter}, 64'd0);
        exp_errs = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Three corrupted packets after reset.
        for (int p = 0; p < 3; p++) begin
            hdr = $urandom();
            sub = rand_sub();
            make_parity(hdr, sub, hpar, spar);
            hpar = ~hpar;
            push_exp(hdr, sub, 5'b10000);
            send_pkt(hdr, hpar, sub, spar, 32);
            idle(1);
        end
        idle(3);
`ifdef H14_PKT_ERR_COUNT_EN
        chk("err_count", {48'h0, bus.err_count}, 64'(exp_errs));
        chk("err_count_three", {48'h0, bus.err_count}, 64'd3);
`endif

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
